// File: rtl/audio_mixer_mc_if.sv
// Bundled sample/gain inputs and mix/DAC outputs of the audio mixer.
`timescale 1ns/1ps
interface audio_mixer_mc_if #(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 8,
    parameter int VOL_W    = 6,
    parameter int OUT_W    = 8
);
    logic                      sample_stb;
    logic [CHANNELS*IN_W-1:0]  ch_l;
    logic [CHANNELS*IN_W-1:0]  ch_r;
    logic [CHANNELS*VOL_W-1:0] gain_l;
    logic [CHANNELS*VOL_W-1:0] gain_r;
    logic [VOL_W-1:0]          master_vol;
    logic                      mute;
    logic                      busy;
    logic                      mix_valid;
    logic [OUT_W-1:0]          mix_l;
    logic [OUT_W-1:0]          mix_r;
    logic                      clip_l;
    logic                      clip_r;
    logic                      overrun;
    logic                      audio_l;
    logic                      audio_r;

    modport master (
        output sample_stb, ch_l, ch_r, gain_l, gain_r, master_vol, mute,
        input  busy, mix_valid, mix_l, mix_r, clip_l, clip_r, overrun, audio_l, audio_r
    );

    modport slave (
        input  sample_stb, ch_l, ch_r, gain_l, gain_r, master_vol, mute,
        output busy, mix_valid, mix_l, mix_r, clip_l, clip_r, overrun, audio_l, audio_r
    );
endinterface

// File: rtl/audio_mixer_mc.sv
// N-channel stereo mixer: snapshot on strobe, per-channel MAC, master gain, saturate,
// then first-order sigma-delta modulators for the 1-bit audio pins.
`timescale 1ns/1ps
module audio_mixer_mc #(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 8,
    parameter int VOL_W    = 6,
    parameter int OUT_W    = 8
) (
    input  logic             clk_32,
    input  logic             reset_l,
    audio_mixer_mc_if.slave  bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW = IN_W + 1 + $clog2(CHANNELS);
    // Master stage can reach ~2x the accumulator; keep at least OUT_W+1 bits for the clip test
    localparam int MW = (AW + 1 > OUT_W + 1) ? AW + 1 : OUT_W + 1;
    localparam int PW = IN_W + VOL_W;
    localparam int FW = AW + VOL_W;
    localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, ACC, MASTER, OUT} state_t;
    state_t state;

    logic [CHANNELS*IN_W-1:0]  snap_ch_l, snap_ch_r;
    logic [CHANNELS*VOL_W-1:0] snap_gain_l, snap_gain_r;
    logic [VOL_W-1:0]          snap_master;
    logic                      snap_mute;
    logic [CW-1:0]             ch_idx;
    logic [AW-1:0]             acc_l, acc_r;
    logic [MW-1:0]             mres_l, mres_r;
    logic                      busy, mix_valid, clip_l, clip_r, overrun;
    logic [OUT_W-1:0]          mix_l, mix_r;
    logic [OUT_W:0]            dac_l, dac_r;

    logic [PW-1:0] prod_l, prod_r;
    logic [AW-1:0] term_l, term_r;
    logic [FW-1:0] full_l, full_r;
    logic [MW-1:0] scaled_l, scaled_r;
    logic          sat_l, sat_r;

    always_comb begin
        prod_l   = PW'(snap_ch_l[ch_idx*IN_W +: IN_W]) * PW'(snap_gain_l[ch_idx*VOL_W +: VOL_W]);
        prod_r   = PW'(snap_ch_r[ch_idx*IN_W +: IN_W]) * PW'(snap_gain_r[ch_idx*VOL_W +: VOL_W]);
        term_l   = AW'(prod_l >> (VOL_W - 1));
        term_r   = AW'(prod_r >> (VOL_W - 1));
        full_l   = FW'(acc_l) * FW'(snap_master);
        full_r   = FW'(acc_r) * FW'(snap_master);
        scaled_l = MW'(full_l >> (VOL_W - 1));
        scaled_r = MW'(full_r >> (VOL_W - 1));
        sat_l    = |mres_l[MW-1:OUT_W];
        sat_r    = |mres_r[MW-1:OUT_W];
    end

    always_ff @(posedge clk_32 or negedge reset_l) begin
        if (!reset_l) begin
            state       <= IDLE;
            snap_ch_l   <= '0;
            snap_ch_r   <= '0;
            snap_gain_l <= '0;
            snap_gain_r <= '0;
            snap_master <= '0;
            snap_mute   <= 1'b0;
            ch_idx      <= '0;
            acc_l       <= '0;
            acc_r       <= '0;
            mres_l      <= '0;
            mres_r      <= '0;
            busy        <= 1'b0;
            mix_valid   <= 1'b0;
            mix_l       <= '0;
            mix_r       <= '0;
            clip_l      <= 1'b0;
            clip_r      <= 1'b0;
            overrun     <= 1'b0;
            dac_l       <= '0;
            dac_r       <= '0;
        end else begin
            overrun   <= bus.sample_stb && (state != IDLE);
            mix_valid <= 1'b0;
            dac_l     <= {1'b0, dac_l[OUT_W-1:0]} + {1'b0, mix_l};
            dac_r     <= {1'b0, dac_r[OUT_W-1:0]} + {1'b0, mix_r};
            case (state)
                IDLE: begin
                    if (bus.sample_stb) begin
                        snap_ch_l   <= bus.ch_l;
                        snap_ch_r   <= bus.ch_r;
                        snap_gain_l <= bus.gain_l;
                        snap_gain_r <= bus.gain_r;
                        snap_master <= bus.master_vol;
                        snap_mute   <= bus.mute;
                        acc_l       <= '0;
                        acc_r       <= '0;
                        ch_idx      <= '0;
                        busy        <= 1'b1;
                        state       <= ACC;
                    end
                end
                ACC: begin
                    acc_l  <= acc_l + term_l;
                    acc_r  <= acc_r + term_r;
                    ch_idx <= ch_idx + 1'b1;
                    if (ch_idx == LAST) state <= MASTER;
                end
                MASTER: begin
                    mres_l <= scaled_l;
                    mres_r <= scaled_r;
                    state  <= OUT;
                end
                OUT: begin
                    if (snap_mute) begin
                        mix_l  <= '0;
                        mix_r  <= '0;
                        clip_l <= 1'b0;
                        clip_r <= 1'b0;
                    end else begin
                        mix_l  <= sat_l ? '1 : mres_l[OUT_W-1:0];
                        mix_r  <= sat_r ? '1 : mres_r[OUT_W-1:0];
                        clip_l <= sat_l;
                        clip_r <= sat_r;
                    end
                    mix_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.mix_valid = mix_valid;
    assign bus.mix_l     = mix_l;
    assign bus.mix_r     = mix_r;
    assign bus.clip_l    = clip_l;
    assign bus.clip_r    = clip_r;
    assign bus.overrun   = overrun;
    assign bus.audio_l   = dac_l[OUT_W];
    assign bus.audio_r   = dac_r[OUT_W];
endmodule
